// File: rtl/inst_fetch.sv
// Instruction fetch stage with IF/ID pipe register.
// Single-outstanding imem requests, freeze hold buffer, branch redirect/flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freezeIn,
  input  logic        branchTakenIn,
  input  logic [31:0] branchAddrIn,
  output logic        imemReqOut,
  output logic [31:0] imemAddrOut,
  input  logic [31:0] imemRdataIn,
  input  logic        imemValidIn,
  output logic [31:0] instructionOut,
  output logic [31:0] pcOut,
  output logic        validOut
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4;
  logic        kill;
  logic        killNext;
  logic [31:0] holdInstr;
  logic [31:0] holdInstrNext;
  logic [31:0] holdPc;
  logic [31:0] holdPcNext;
  logic        deliver;
  logic [31:0] deliverInstr;
  logic [31:0] deliverPc;

  assign pcPlus4     = pc + 32'd4;
  assign imemAddrOut = pc;
  assign imemReqOut  = (state == ISSUE) & ~branchTakenIn & ~rst;

  // Next-state: fetch sequencing, kill tracking and hold buffer capture
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    killNext      = kill;
    holdInstrNext = holdInstr;
    holdPcNext    = holdPc;
    deliver       = 1'b0;
    deliverInstr  = imemRdataIn;
    deliverPc     = pcPlus4;
    case (state)
      ISSUE: begin
        if (branchTakenIn) begin
          pcNext = branchAddrIn;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (!imemValidIn) begin
          if (branchTakenIn) begin
            killNext = 1'b1;
            pcNext   = branchAddrIn;
          end
        end else if (kill || branchTakenIn) begin
          killNext  = 1'b0;
          stateNext = ISSUE;
          if (branchTakenIn) begin
            pcNext = branchAddrIn;
          end
        end else if (freezeIn) begin
          holdInstrNext = imemRdataIn;
          holdPcNext    = pcPlus4;
          stateNext     = HOLD;
        end else begin
          deliver   = 1'b1;
          pcNext    = pcPlus4;
          stateNext = ISSUE;
        end
      end
      HOLD: begin
        if (branchTakenIn) begin
          pcNext    = branchAddrIn;
          stateNext = ISSUE;
        end else if (!freezeIn) begin
          deliver      = 1'b1;
          deliverInstr = holdInstr;
          deliverPc    = holdPc;
          pcNext       = pcPlus4;
          stateNext    = ISSUE;
        end
      end
      default: begin
        stateNext = ISSUE;
      end
    endcase
  end

  // Fetch control state; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      holdInstr <= NOP_INSTR;
      holdPc    <= 32'h0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      kill      <= killNext;
      holdInstr <= holdInstrNext;
      holdPc    <= holdPcNext;
    end
  end

  // IF/ID register: branch flush beats freeze, freeze beats load
  always_ff @(posedge clk) begin
    if (rst) begin
      instructionOut <= NOP_INSTR;
      pcOut          <= 32'h0;
      validOut       <= 1'b0;
    end else if (branchTakenIn) begin
      instructionOut <= NOP_INSTR;
      validOut       <= 1'b0;
    end else if (freezeIn) begin
      instructionOut <= instructionOut;
    end else if (deliver) begin
      instructionOut <= deliverInstr;
      pcOut          <= deliverPc;
      validOut       <= 1'b1;
    end else begin
      instructionOut <= NOP_INSTR;
      validOut       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch.
// Scenario tasks with a queue scoreboard of delivered IF/ID entries.
module tb_inst_fetch;

  localparam logic [31:0] NOP1 = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freezeIn = 1'b0;
  logic        branchTakenIn = 1'b0;
  logic [31:0] branchAddrIn = 32'h0;
  logic        imemReqOut;
  logic [31:0] imemAddrOut;
  logic [31:0] imemRdataIn = 32'h0;
  logic        imemValidIn = 1'b0;
  logic [31:0] instructionOut;
  logic [31:0] pcOut;
  logic        validOut;

  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2 = 32'h0;
  logic        valid2 = 1'b0;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        vout2;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [63:0] e;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .NOP_INSTR(NOP1)) u1 (
    .clk(clk), .rst(rst), .freezeIn(freezeIn),
    .branchTakenIn(branchTakenIn), .branchAddrIn(branchAddrIn),
    .imemReqOut(imemReqOut), .imemAddrOut(imemAddrOut),
    .imemRdataIn(imemRdataIn), .imemValidIn(imemValidIn),
    .instructionOut(instructionOut), .pcOut(pcOut), .validOut(validOut)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u2 (
    .clk(clk), .rst(rst2), .freezeIn(1'b0),
    .branchTakenIn(1'b0), .branchAddrIn(32'h0),
    .imemReqOut(req2), .imemAddrOut(addr2),
    .imemRdataIn(rdata2), .imemValidIn(valid2),
    .instructionOut(instr2), .pcOut(pc2), .validOut(vout2)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nextCycle();
    nextCycle();
    #1;
    checks++;
    if (validOut !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", validOut);
    end
    checks++;
    if (instructionOut !== NOP1) begin
      failures++;
      $display("FAIL reset_instr got=%h exp=%h", instructionOut, NOP1);
    end
    checks++;
    if (pcOut !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=0", pcOut);
    end
    checks++;
    if (imemReqOut !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got=%b exp=0", imemReqOut);
    end
  endtask

  task automatic test_stream();
    nextCycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL req0 got=%b/%h exp=1/0", imemReqOut, imemAddrOut);
    end
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0000;
    sb.push_back({32'hA000_0000, 32'h4});
    #1;
    checks++;
    if (imemReqOut !== 1'b0) begin
      failures++;
      $display("FAIL wait_noreq got=%b exp=0", imemReqOut);
    end
    nextCycle();
    imemValidIn = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_c2 got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instructionOut, pcOut, validOut} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_c2 got=%h/%h/%b exp=%h/1", instructionOut, pcOut, validOut, e);
      end
    end
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'h4}) begin
      failures++;
      $display("FAIL req4 got=%b/%h exp=1/4", imemReqOut, imemAddrOut);
    end
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0004;
    sb.push_back({32'hA000_0004, 32'h8});
    #1;
    checks++;
    if (validOut !== 1'b0) begin
      failures++;
      $display("FAIL bubble_c3 got=%b exp=0", validOut);
    end
    nextCycle();
    imemValidIn = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_c4 got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instructionOut, pcOut, validOut} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_c4 got=%h/%h/%b exp=%h/1", instructionOut, pcOut, validOut, e);
      end
    end
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'h8}) begin
      failures++;
      $display("FAIL req8 got=%b/%h exp=1/8", imemReqOut, imemAddrOut);
    end
  endtask

  task automatic test_freeze();
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0008;
    freezeIn = 1'b1;
    sb.push_back({32'hA000_0008, 32'd12});
    #1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      imemValidIn = 1'b0;
      #1;
      checks++;
      if ({imemReqOut, validOut, pcOut} !== {1'b0, 1'b0, 32'h8}) begin
        failures++;
        $display("FAIL hold_%0d got=req%b/v%b/%h exp=0/0/8", i, imemReqOut, validOut, pcOut);
      end
    end
    nextCycle();
    freezeIn = 1'b0;
    #1;
    checks++;
    if (imemReqOut !== 1'b0) begin
      failures++;
      $display("FAIL hold_release_req got=%b exp=0", imemReqOut);
    end
    nextCycle();
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_freeze got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instructionOut, pcOut, validOut} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_freeze got=%h/%h/%b exp=%h/1", instructionOut, pcOut, validOut, e);
      end
    end
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'd12}) begin
      failures++;
      $display("FAIL req12 got=%b/%h exp=1/c", imemReqOut, imemAddrOut);
    end
  endtask

  task automatic test_branch_wait();
    nextCycle();
    #1;
    nextCycle();
    branchTakenIn = 1'b1;
    branchAddrIn = 32'h100;
    #1;
    checks++;
    if (imemReqOut !== 1'b0) begin
      failures++;
      $display("FAIL bw_req got=%b exp=0", imemReqOut);
    end
    nextCycle();
    branchTakenIn = 1'b0;
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_000C;
    #1;
    checks++;
    if ({validOut, instructionOut} !== {1'b0, NOP1}) begin
      failures++;
      $display("FAIL bw_flush got=%b/%h exp=0/%h", validOut, instructionOut, NOP1);
    end
    nextCycle();
    imemValidIn = 1'b0;
    #1;
    checks++;
    if (validOut !== 1'b0) begin
      failures++;
      $display("FAIL bw_discard got=%b exp=0", validOut);
    end
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL req100 got=%b/%h exp=1/100", imemReqOut, imemAddrOut);
    end
  endtask

  task automatic test_branch_response();
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0100;
    sb.push_back({32'hA000_0100, 32'h104});
    #1;
    nextCycle();
    imemValidIn = 1'b0;
    freezeIn = 1'b1;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_br got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instructionOut, pcOut, validOut} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_br got=%h/%h/%b exp=%h/1", instructionOut, pcOut, validOut, e);
      end
    end
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'h104}) begin
      failures++;
      $display("FAIL req104_frozen got=%b/%h exp=1/104", imemReqOut, imemAddrOut);
    end
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0104;
    branchTakenIn = 1'b1;
    branchAddrIn = 32'h200;
    #1;
    checks++;
    if ({validOut, pcOut} !== {1'b1, 32'h104}) begin
      failures++;
      $display("FAIL frozen_entry got=%b/%h exp=1/104", validOut, pcOut);
    end
    nextCycle();
    imemValidIn = 1'b0;
    branchTakenIn = 1'b0;
    freezeIn = 1'b0;
    #1;
    checks++;
    if ({instructionOut, pcOut, validOut} !== {NOP1, 32'h104, 1'b0}) begin
      failures++;
      $display("FAIL br_flush got=%h/%h/%b exp=%h/104/0", instructionOut, pcOut, validOut, NOP1);
    end
    checks++;
    if ({imemReqOut, imemAddrOut} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL req200 got=%b/%h exp=1/200", imemReqOut, imemAddrOut);
    end
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0200;
    sb.push_back({32'hA000_0200, 32'h204});
    #1;
    nextCycle();
    imemValidIn = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_200 got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instructionOut, pcOut, validOut} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_200 got=%h/%h/%b exp=%h/1", instructionOut, pcOut, validOut, e);
      end
    end
  endtask

  task automatic test_reset_wait();
    nextCycle();
    rst = 1'b1;
    #1;
    checks++;
    if (imemReqOut !== 1'b0) begin
      failures++;
      $display("FAIL rw_req_a got=%b exp=0", imemReqOut);
    end
    nextCycle();
    #1;
    checks++;
    if ({imemReqOut, validOut, pcOut} !== {1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL rw_req_b got=%b/%b/%h exp=0/0/0", imemReqOut, validOut, pcOut);
    end
    nextCycle();
    rst = 1'b0;
    imemValidIn = 1'b1;
    imemRdataIn = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({imemReqOut, imemAddrOut, validOut} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL rw_first_req got=%b/%h/%b exp=1/0/0", imemReqOut, imemAddrOut, validOut);
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      imemValidIn = 1'b0;
      #1;
      checks++;
      if ({validOut, imemReqOut} !== 2'b00) begin
        failures++;
        $display("FAIL rw_stale_%0d got=%b/%b exp=0/0", i, validOut, imemReqOut);
      end
    end
    nextCycle();
    imemValidIn = 1'b1;
    imemRdataIn = 32'hA000_0000;
    sb.push_back({32'hA000_0000, 32'h4});
    #1;
    checks++;
    if (validOut !== 1'b0) begin
      failures++;
      $display("FAIL rw_pre got=%b exp=0", validOut);
    end
    nextCycle();
    imemValidIn = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_rw got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instructionOut, pcOut, validOut} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_rw got=%h/%h/%b exp=%h/1", instructionOut, pcOut, validOut, e);
      end
    end
  endtask

  task automatic test_wrap();
    nextCycle();
    rst2 = 1'b0;
    #1;
    checks++;
    if ({req2, addr2, vout2} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      failures++;
      $display("FAIL wrap_req got=%b/%h/%b exp=1/fffffffc/0", req2, addr2, vout2);
    end
    nextCycle();
    valid2 = 1'b1;
    rdata2 = 32'hFFFF_FFFC;
    sb.push_back({32'hFFFF_FFFC, 32'h0});
    #1;
    nextCycle();
    valid2 = 1'b0;
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty_wrap got=empty exp=entry");
    end else begin
      e = sb.pop_front();
      if ({instr2, pc2, vout2} !== {e, 1'b1}) begin
        failures++;
        $display("FAIL ifid_wrap got=%h/%h/%b exp=%h/1", instr2, pc2, vout2, e);
      end
    end
    checks++;
    if ({req2, addr2} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_next got=%b/%h exp=1/0", req2, addr2);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch_wait();
    test_branch_response();
    test_reset_wait();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage plus IF/ID pipe register. It is the producer side of the decode stage's instruction/PC input.
- Generates the fetch PC and issues single-outstanding requests to the instruction memory.
- Delivers {instruction, PC+4, valid} to decode.
- Honours the hazard freeze and the branch-taken redirect/flush coming back from the pipeline.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven on instructionOut when flushed or reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
freezeIn  input  1  hazard stall from hazard unit; IF/ID and PC hold
branchTakenIn  input  1  branch resolved taken this cycle; redirect and flush
branchAddrIn  input  32  branch target, valid when branchTakenIn=1
imemReqOut  output  1  one-cycle fetch request pulse
imemAddrOut  output  32  fetch address, valid while imemReqOut=1
imemRdataIn  input  32  instruction word, valid when imemValidIn=1
imemValidIn  input  1  response strobe; exactly one per request, ≥1 cycle after it
instructionOut  output  32  IF/ID instruction to decode
pcOut  output  32  IF/ID PC+4 of that instruction
validOut  output  1  IF/ID entry holds a real instruction

Behaviour:
- Internal state: pc[31:0], FSM {ISSUE, WAIT, HOLD}, kill flag, holdInstr[31:0], holdPc[31:0].
- Reset (rst=1 at edge): pc=RESET_PC, FSM=ISSUE, kill=0, instructionOut=NOP_INSTR, pcOut=0, validOut=0. imemReqOut is forced 0 in any cycle rst=1. Reset mid-WAIT abandons the request; a late imemValidIn in ISSUE is ignored.
- imemReqOut = (FSM==ISSUE) & ~branchTakenIn & ~rst; imemAddrOut = pc. At most one request outstanding.
- FSM transitions:
  - ISSUE:
    - branchTakenIn=1 → pc<=branchAddrIn, no request, stay ISSUE.
    - Otherwise → WAIT. Freeze does not block issue.
  - WAIT, imemValidIn=0:
    - branchTakenIn=1 → kill<=1, pc<=branchAddrIn.
    - Otherwise stay.
  - WAIT, imemValidIn=1:
    - kill=1 or branchTakenIn=1 → discard word, kill<=0, pc<=branchAddrIn if branchTakenIn, → ISSUE.
    - Else freezeIn=1 → holdInstr<=imemRdataIn, holdPc<=pc+4, → HOLD.
    - Else load IF/ID {imemRdataIn, pc+4, 1}, pc<=pc+4, → ISSUE.
  - HOLD:
    - branchTakenIn=1 → discard hold, pc<=branchAddrIn, → ISSUE.
    - Else freezeIn=0 → load IF/ID {holdInstr, holdPc, 1}, pc<=pc+4, → ISSUE.
    - Else stay.
- IF/ID register update, in priority order:
  1. rst.
  2. branchTakenIn → instructionOut=NOP_INSTR, validOut=0; pcOut holds.
  3. freezeIn → all hold.
  4. New word delivered (as above) → load.
  5. Otherwise bubble: validOut=0, instructionOut=NOP_INSTR; pcOut holds.
- Branch always beats freeze. Simultaneous branch and response drops the response.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. branchAddrIn is used unmodified (no alignment forcing).
- Latency: with 1-cycle memory, one instruction per 2 cycles. validOut rises on the edge that closes the response cycle.

Test Plan:
- Reset, then 1-cycle memory returning addr-tagged words (word=addr|0xA000_0000):
  - req at cycle0 with addr 0.
  - validOut=1, instructionOut=0xA000_0000, pcOut=4 in cycle2.
  - Next req addr 4 in cycle2; validOut=0 in cycle3, =1 with pcOut=8 in cycle4.
- Freeze held 4 cycles starting as response for addr 8 arrives:
  - FSM enters HOLD; IF/ID keeps the addr-4 entry; no new req.
  - On release, IF/ID={0xA000_0008, 12, 1}; next req addr 12.
- 3-cycle memory latency, branchTakenIn=1 with branchAddrIn=0x100 in the middle of WAIT:
  - Response word discarded; validOut=0 that cycle.
  - Next req addr 0x100.
- branchTakenIn and imemValidIn in the same cycle, with freezeIn=1:
  - Word dropped, IF/ID flushed (validOut=0, NOP_INSTR).
  - Next req addr = branchAddrIn.
- RESET_PC=32'hFFFF_FFFC: first req addr 0xFFFF_FFFC, delivered pcOut=0, next req addr 0.
- rst asserted while in WAIT; response arrives one cycle after rst drops:
  - Response ignored.
  - First post-reset req addr RESET_PC; validOut stays 0 until its response.
